mbist_mux_nrep: RTL and testbench

Next-generation MBIST/functional memory port mux for one single-port SRAM, running on a single clock. It replaces the single-entry repair with a parametrised multi-entry repair table (BIST_REPAIR_CNT spare words). The table allocates spares automatically on BIST errors, remaps matching addresses in both BIST and functional mode, and is readable and writable over a serial repair chain. It sits between mbist_ctrl and the SRAM macro, one instance per memory.

---
 rtl/mbist_mux_nrep_if.sv | 18 +
 rtl/mbist_mux_nrep.sv | 97 +++++++++
 tb/tb_mbist_mux_nrep.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mbist_mux_nrep_if.sv
// mbist_mux_nrep_if: SRAM-side bus between the mux and one single-port SRAM macro.
// Ports (master = mux, slave = SRAM):
//   cen  active-low chip enable      web  active-low write enable
//   mask byte mask                   addr remapped address
//   din  write data                  dout read data from SRAM
interface mbist_mux_nrep_if #(
    parameter int ADDR_WD = 9,
    parameter int DATA_WD = 32
);
    logic                   cen;
    logic                   web;
    logic [DATA_WD/8-1:0]   mask;
    logic [ADDR_WD-1:0]     addr;
    logic [DATA_WD-1:0]     din;
    logic [DATA_WD-1:0]     dout;
    modport master (output cen, web, mask, addr, din, input dout);
    modport slave (input cen, web, mask, addr, din, output dout);
endinterface

// File: rtl/mbist_mux_nrep.sv
// mbist_mux_nrep: BIST/functional SRAM port mux with a multi-entry repair table.
// Ports:
//   clk, rst                   single clock, synchronous active-high reset
//   scan_mode                  DFT scan: func_dout reflects mem din
//   bist_*                     BIST access, error capture, table load and serial repair chain
//   bist_sdo                   repair chain serial out (valid bit of the last entry)
//   bist_correct, bist_rep_cnt no overflow so far / number of valid entries
//   func_*                     functional access (cen/web active-low)
//   mem                        SRAM bus (master side), address remapped through the table
module mbist_mux_nrep #(
    parameter int                     BIST_ADDR_WD           = 9,
    parameter int                     BIST_DATA_WD           = 32,
    parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START        = 9'h000,
    parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END          = 9'h1F7,
    parameter logic [BIST_ADDR_WD-1:0] BIST_REPAIR_ADDR_START = 9'h1F8,
    parameter int                     BIST_REPAIR_CNT        = 4,
    parameter int                     BIST_CNT_WD            = $clog2(BIST_REPAIR_CNT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      scan_mode,
    input  logic                      bist_en,
    input  logic [BIST_ADDR_WD-1:0]   bist_addr,
    input  logic [BIST_DATA_WD-1:0]   bist_wdata,
    input  logic                      bist_wr,
    input  logic                      bist_rd,
    input  logic                      bist_error,
    input  logic [BIST_ADDR_WD-1:0]   bist_error_addr,
    input  logic                      bist_load,
    input  logic                      bist_shift,
    input  logic                      bist_sdi,
    output logic                      bist_sdo,
    output logic                      bist_correct,
    output logic [BIST_CNT_WD-1:0]    bist_rep_cnt,
    input  logic                      func_cen,
    input  logic                      func_web,
    input  logic [BIST_DATA_WD/8-1:0] func_mask,
    input  logic [BIST_ADDR_WD-1:0]   func_addr,
    input  logic [BIST_DATA_WD-1:0]   func_din,
    output logic [BIST_DATA_WD-1:0]   func_dout,
    mbist_mux_nrep_if.master          mem
);
    if (BIST_REPAIR_CNT < 1 || BIST_REPAIR_CNT > 16 || BIST_ADDR_START > BIST_ADDR_END ||
        BIST_REPAIR_ADDR_START <= BIST_ADDR_END) begin : g_bad_cfg
        $error("mbist_mux_nrep: spares must lie above the testable range and count must be 1..16");
    end
    logic [BIST_REPAIR_CNT-1:0] valid;
    logic [BIST_ADDR_WD-1:0]    eaddr [BIST_REPAIR_CNT];
    logic                       overflow;
    logic [BIST_ADDR_WD-1:0]    addr;
    logic                       err_hit;
    logic [BIST_REPAIR_CNT-1:0] free_oh;
    logic [BIST_REPAIR_CNT-1:0] chain_in;
    // serial input of each entry: sdi for entry 0, previous entry's valid bit otherwise
    assign chain_in     = BIST_REPAIR_CNT'({valid, bist_sdi});
    assign bist_sdo     = valid[BIST_REPAIR_CNT-1];
    assign bist_correct = !overflow;
    assign func_dout    = scan_mode ? mem.din : mem.dout;
    // descending loop so the lowest matching / free index is the one that sticks
    always_comb begin
        addr         = bist_en ? bist_addr : func_addr;
        mem.cen      = bist_en ? !(bist_rd || bist_wr) : func_cen;
        mem.web      = bist_en ? !bist_wr : func_web;
        mem.mask     = bist_en ? '1 : func_mask;
        mem.din      = bist_en ? bist_wdata : func_din;
        mem.addr     = addr;
        err_hit      = 1'b0;
        free_oh      = '0;
        bist_rep_cnt = '0;
        for (int i = BIST_REPAIR_CNT - 1; i >= 0; i--) begin
            if (valid[i] && eaddr[i] == addr) mem.addr = BIST_REPAIR_ADDR_START + BIST_ADDR_WD'(i);
            if (!valid[i]) free_oh = BIST_REPAIR_CNT'(1) << i;
            err_hit      = err_hit || (valid[i] && eaddr[i] == bist_error_addr);
            bist_rep_cnt = bist_rep_cnt + BIST_CNT_WD'(valid[i]);
        end
    end
    always_ff @(posedge clk) begin
        if (rst || bist_load) begin
            valid    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < BIST_REPAIR_CNT; i++) eaddr[i] <= '0;
        end else if (bist_shift) begin
            for (int i = 0; i < BIST_REPAIR_CNT; i++) begin
                valid[i] <= eaddr[i][BIST_ADDR_WD-1];
                eaddr[i] <= {eaddr[i][BIST_ADDR_WD-2:0], chain_in[i]};
            end
        end else if (bist_error && bist_en && !err_hit) begin
            if (free_oh == '0) overflow <= 1'b1;
            for (int i = 0; i < BIST_REPAIR_CNT; i++) begin
                if (free_oh[i]) begin
                    valid[i] <= 1'b1;
                    eaddr[i] <= bist_error_addr;
                end
            end
        end
    end
endmodule

// File: tb/tb_mbist_mux_nrep.sv
// tb_mbist_mux_nrep: directed and randomized self-checking bench for mbist_mux_nrep.
module tb_mbist_mux_nrep;
    localparam int AW = 9, DW = 32, CNT = 4, CW = 3;
    localparam logic [AW-1:0] SPARE = 9'h1F8;
    logic clk = 1'b0, rst = 1'b1, scan_mode = 1'b0;
    logic bist_en = 1'b0, bist_wr = 1'b0, bist_rd = 1'b0, bist_error = 1'b0;
    logic bist_load = 1'b0, bist_shift = 1'b0, bist_sdi = 1'b0, bist_sdo, bist_correct;
    logic [AW-1:0] bist_addr = '0, bist_error_addr = '0, func_addr = '0;
    logic [DW-1:0] bist_wdata = '0, func_din = '0, func_dout;
    logic [CW-1:0] bist_rep_cnt;
    logic func_cen = 1'b1, func_web = 1'b1;
    logic [DW/8-1:0] func_mask = '0;
    int tests = 0, fails = 0;
    mbist_mux_nrep_if #(.ADDR_WD(AW), .DATA_WD(DW)) mem_if ();
    mbist_mux_nrep dut (
        .clk(clk), .rst(rst), .scan_mode(scan_mode), .bist_en(bist_en), .bist_addr(bist_addr),
        .bist_wdata(bist_wdata), .bist_wr(bist_wr), .bist_rd(bist_rd), .bist_error(bist_error),
        .bist_error_addr(bist_error_addr), .bist_load(bist_load), .bist_shift(bist_shift),
        .bist_sdi(bist_sdi), .bist_sdo(bist_sdo), .bist_correct(bist_correct),
        .bist_rep_cnt(bist_rep_cnt), .func_cen(func_cen), .func_web(func_web),
        .func_mask(func_mask), .func_addr(func_addr), .func_din(func_din),
        .func_dout(func_dout), .mem(mem_if.master)
    );
    always #5 clk = !clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // inputs change 1 time unit after the rising edge; checks follow another unit later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic err_cycle(input logic [AW-1:0] a);
        bist_error = 1'b1;
        bist_error_addr = a;
        cyc();
        bist_error = 1'b0;
    endtask
    task automatic load();
        bist_load = 1'b1;
        cyc();
        bist_load = 1'b0;
    endtask
    initial begin
        logic [39:0] chain;
        int q[$];
        bit ovf;
        mem_if.dout = 32'hDEAD_BEEF;
        cyc();
        cyc();
        rst = 1'b0;
        func_cen = 1'b0;
        func_web = 1'b0;
        func_addr = 9'h010;
        func_mask = 4'hA;
        func_din = 32'h1234_5678;
        #1;
        chk("rst_addr", mem_if.addr, 9'h010);
        chk("rst_web", mem_if.web, 1'b0);
        chk("rst_cen", mem_if.cen, 1'b0);
        chk("rst_mask", mem_if.mask, 4'hA);
        chk("rst_din", mem_if.din, 32'h1234_5678);
        chk("rst_dout", func_dout, 32'hDEAD_BEEF);
        chk("rst_correct", bist_correct, 1'b1);
        chk("rst_cnt", bist_rep_cnt, 0);
        chk("rst_sdo", bist_sdo, 1'b0);
        bist_en = 1'b1;
        err_cycle(9'h020);
        err_cycle(9'h045);
        chk("t2_cnt", bist_rep_cnt, 2);
        bist_rd = 1'b1;
        bist_addr = 9'h020;
        #1;
        chk("t2_map020", mem_if.addr, 9'h1F8);
        chk("t2_cen", mem_if.cen, 1'b0);
        chk("t2_web", mem_if.web, 1'b1);
        chk("t2_mask", mem_if.mask, 4'hF);
        bist_addr = 9'h045;
        #1;
        chk("t2_map045", mem_if.addr, 9'h1F9);
        bist_addr = 9'h046;
        #1;
        chk("t2_map046", mem_if.addr, 9'h046);
        bist_rd = 1'b0;
        bist_en = 1'b0;
        func_addr = 9'h045;
        #1;
        chk("t2_func_map", mem_if.addr, 9'h1F9);
        bist_en = 1'b1;
        load();
        chk("t3_load_cnt", bist_rep_cnt, 0);
        bist_error = 1'b1;
        bist_error_addr = 9'h020;
        cyc();
        cyc();
        cyc();
        bist_error = 1'b0;
        chk("t3_cnt", bist_rep_cnt, 1);
        chk("t3_correct", bist_correct, 1'b1);
        load();
        for (int k = 1; k <= 5; k++) begin
            err_cycle(AW'(k));
            if (k == 4) chk("t4_cnt4", bist_rep_cnt, 4);
            if (k == 4) chk("t4_ok4", bist_correct, 1'b1);
        end
        chk("t4_cnt", bist_rep_cnt, 4);
        chk("t4_correct", bist_correct, 1'b0);
        bist_addr = 9'h004;
        #1;
        chk("t4_map4", mem_if.addr, 9'h1FB);
        bist_addr = 9'h005;
        #1;
        chk("t4_map5", mem_if.addr, 9'h005);
        load();
        chk("t4_load_cnt", bist_rep_cnt, 0);
        chk("t4_load_ok", bist_correct, 1'b1);
        err_cycle(9'h020);
        chain = {30'b0, 1'b1, 9'h020};
        bist_shift = 1'b1;
        bist_sdi = 1'b0;
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("t5_sdo%0d", k), bist_sdo, chain[39-k]);
            cyc();
        end
        chk("t5_empty", bist_rep_cnt, 0);
        chain = {1'b1, 9'h0AA, 30'b0};
        for (int k = 0; k < 40; k++) begin
            bist_sdi = chain[39-k];
            cyc();
        end
        bist_shift = 1'b0;
        bist_sdi = 1'b0;
        bist_en = 1'b0;
        func_addr = 9'h0AA;
        #1;
        chk("t5_cnt", bist_rep_cnt, 1);
        chk("t5_map", mem_if.addr, 9'h1FB);
        chk("t5_sdo", bist_sdo, 1'b1);
        bist_en = 1'b1;
        load();
        bist_shift = 1'b1;
        err_cycle(9'h033);
        bist_shift = 1'b0;
        bist_addr = 9'h033;
        #1;
        chk("t6_cnt", bist_rep_cnt, 0);
        chk("t6_map", mem_if.addr, 9'h033);
        scan_mode = 1'b1;
        bist_wdata = 32'hA5A5_0F0F;
        mem_if.dout = 32'h0000_1111;
        #1;
        chk("t6_scan", func_dout, 32'hA5A5_0F0F);
        scan_mode = 1'b0;
        #1;
        chk("t6_noscan", func_dout, 32'h0000_1111);
        // random errors and lookups against an ordered list of allocated addresses
        load();
        ovf = 1'b0;
        for (int it = 0; it < 300; it++) begin
            int idx;
            logic [AW-1:0] ea, ba, exp_addr;
            bit err;
            ea = AW'($urandom_range(0, 7));
            ba = AW'($urandom_range(0, 7));
            err = ($urandom_range(0, 3) == 0);
            if (it % 60 == 59) begin
                load();
                q.delete();
                ovf = 1'b0;
            end
            bist_error = err;
            bist_error_addr = ea;
            bist_addr = ba;
            #1;
            idx = -1;
            foreach (q[j]) if (q[j] == int'(ba) && idx < 0) idx = j;
            exp_addr = (idx >= 0) ? SPARE + AW'(idx) : ba;
            chk("rnd_map", mem_if.addr, exp_addr);
            chk("rnd_cnt", bist_rep_cnt, q.size());
            chk("rnd_correct", bist_correct, !ovf);
            cyc();
            if (err) begin
                idx = -1;
                foreach (q[j]) if (q[j] == int'(ea)) idx = j;
                if (idx < 0) begin
                    if (q.size() < CNT) q.push_back(int'(ea));
                    else ovf = 1'b1;
                end
            end
        end
        bist_error = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
